// File: rtl/obi_credit_arb.sv
// obi_credit_arb
//   Shares one OBI manager port among NumSbrPorts requesters using weighted
//   round-robin arbitration with a per-port outstanding-transaction credit
//   limit. Produces the per-port grant vector and the selected index for an
//   external A-channel mux, and retires credits as responses come back.
//   Once a request is presented to the manager without a grant, the selection
//   is locked until the grant arrives so the OBI A-phase stays stable.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   req_i        per-port OBI req
//   gnt_o        per-port OBI gnt (at most one bit set)
//   weight_i     packed per-port weights, port i at [i*WeightWidth +: WeightWidth]
//   mgr_req_o    request towards the manager port
//   mgr_gnt_i    grant from the manager port
//   sel_idx_o    index of the port whose A channel drives the manager port
//   rsp_valid_i  a response handshake completed
//   rsp_idx_i    port owning that response
//   idle_o       no transactions outstanding on any port
//
// Configuration
//   OBI_CREDIT_ARB_ASSERT_EN  compile in protocol/consistency assertions

module obi_credit_arb #(
  parameter  int unsigned NumSbrPorts    = 2,
  parameter  int unsigned MaxOutstanding = 4,
  parameter  int unsigned WeightWidth    = 4,
  localparam int unsigned IdxWidth       = (NumSbrPorts > 1) ? $clog2(NumSbrPorts) : 1,
  localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumSbrPorts-1:0]             req_i,
  output logic [NumSbrPorts-1:0]             gnt_o,
  input  logic [NumSbrPorts*WeightWidth-1:0] weight_i,
  output logic                               mgr_req_o,
  input  logic                               mgr_gnt_i,
  output logic [IdxWidth-1:0]                sel_idx_o,
  input  logic                               rsp_valid_i,
  input  logic [IdxWidth-1:0]                rsp_idx_i,
  output logic                               idle_o
);

  if (NumSbrPorts < 2) begin : g_bad_ports
    $fatal(1, "obi_credit_arb: NumSbrPorts must be at least 2");
  end
  if (MaxOutstanding < 1) begin : g_bad_outstanding
    $fatal(1, "obi_credit_arb: MaxOutstanding must be at least 1");
  end

  typedef enum logic {
    StArb,
    StLocked
  } state_e;

  state_e                  state_q, state_d;
  logic [IdxWidth-1:0]     ptr_q, ptr_d;
  logic [IdxWidth-1:0]     lock_idx_q, lock_idx_d;
  logic [WeightWidth-1:0]  q_q, q_d;
  logic [CntWidth-1:0]     cnt_q [NumSbrPorts];
  logic [CntWidth-1:0]     cnt_d [NumSbrPorts];

  logic [NumSbrPorts-1:0]  eligible;
  logic                    any_eligible;
  logic [IdxWidth-1:0]     winner;
  logic                    mgr_req;
  logic [IdxWidth-1:0]     sel;
  logic                    grant;
  logic [WeightWidth-1:0]  weight_arr [NumSbrPorts];
  logic [WeightWidth-1:0]  eff_w;
  logic [WeightWidth:0]    qn;

  // ---------------------------------------------------------------------------
  // Eligibility and round-robin winner
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NumSbrPorts; i++) begin : g_port
    assign eligible[i]   = req_i[i] && (cnt_q[i] < CntWidth'(MaxOutstanding));
    assign weight_arr[i] = weight_i[i*WeightWidth +: WeightWidth];
  end

  assign any_eligible = |eligible;

  // First eligible port scanning ptr, ptr+1, ... with wrap; falls back to ptr
  // when nobody is eligible so sel_idx_o idles on the current owner.
  always_comb begin
    int unsigned idx;
    logic        found;
    winner = ptr_q;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NumSbrPorts; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NumSbrPorts) idx = idx - NumSbrPorts;
      if (!found && eligible[idx[IdxWidth-1:0]]) begin
        found  = 1'b1;
        winner = idx[IdxWidth-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StArb;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    unique case (state_q)
      StArb: begin
        if (any_eligible && !mgr_gnt_i) begin
          state_d    = StLocked;
          lock_idx_d = winner;
        end
      end
      StLocked: begin
        if (mgr_gnt_i) state_d = StArb;
      end
      default: state_d = StArb;
    endcase
  end

  // While locked the request is held even if the owner drops req_i, so the
  // manager never sees a retracted A-phase.
  always_comb begin
    mgr_req = 1'b0;
    sel     = ptr_q;
    unique case (state_q)
      StArb: begin
        mgr_req = any_eligible;
        sel     = winner;
      end
      StLocked: begin
        mgr_req = 1'b1;
        sel     = lock_idx_q;
      end
      default: begin
        mgr_req = 1'b0;
        sel     = ptr_q;
      end
    endcase
  end

  assign grant     = mgr_req && mgr_gnt_i;
  assign mgr_req_o = mgr_req;
  assign sel_idx_o = sel;

  always_comb begin
    gnt_o = '0;
    if (grant) gnt_o[sel] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Weighted quantum: the owner keeps priority until it has received eff_w
  // grants; a grant to a non-owner starts a fresh quantum for that port.
  // ---------------------------------------------------------------------------
  assign eff_w = (weight_arr[sel] == '0) ? WeightWidth'(1) : weight_arr[sel];
  assign qn    = ((sel == ptr_q) ? {1'b0, q_q} : '0) + (WeightWidth + 1)'(1);

  always_comb begin
    ptr_d = ptr_q;
    q_d   = q_q;
    if (grant) begin
      if (qn >= {1'b0, eff_w}) begin
        ptr_d = (sel == IdxWidth'(NumSbrPorts - 1)) ? '0 : sel + IdxWidth'(1);
        q_d   = '0;
      end else begin
        ptr_d = sel;
        q_d   = qn[WeightWidth-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding credit counters
  // ---------------------------------------------------------------------------
  always_comb begin
    logic inc;
    logic dec;
    for (int unsigned i = 0; i < NumSbrPorts; i++) begin
      inc      = grant && (sel == IdxWidth'(i));
      dec      = rsp_valid_i && (rsp_idx_i == IdxWidth'(i));
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CntWidth'(1);
      end else if (dec && !inc && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CntWidth'(1);
      end
    end
  end

  always_comb begin
    idle_o = 1'b1;
    for (int unsigned i = 0; i < NumSbrPorts; i++) begin
      if (cnt_q[i] != '0) idle_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      q_q   <= '0;
      for (int unsigned i = 0; i < NumSbrPorts; i++) cnt_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      q_q   <= q_d;
      for (int unsigned i = 0; i < NumSbrPorts; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Assertions
  // ---------------------------------------------------------------------------
`ifdef OBI_CREDIT_ARB_ASSERT_EN
  a_lock_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == StLocked) |-> req_i[lock_idx_q])
    else $error("obi_credit_arb: req_i dropped while locked");

  a_rsp_idx_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_valid_i |-> (32'(rsp_idx_i) < NumSbrPorts))
    else $error("obi_credit_arb: rsp_idx_i out of range");

  a_rsp_has_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rsp_valid_i && (32'(rsp_idx_i) < NumSbrPorts)) |-> (cnt_q[rsp_idx_i] != '0))
    else $error("obi_credit_arb: response retires a port with nothing outstanding");

  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_o))
    else $error("obi_credit_arb: more than one grant");

  for (genvar i = 0; i < NumSbrPorts; i++) begin : g_cnt_chk
    a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
      cnt_q[i] <= CntWidth'(MaxOutstanding))
      else $error("obi_credit_arb: outstanding count above limit");
  end
`else
  // Assertions compiled out; behaviour is unchanged.
`endif

endmodule

// File: tb/tb_obi_credit_arb.sv
// Directed testbench for obi_credit_arb (NumSbrPorts=4, MaxOutstanding=2).
// The driver pushes the hand-computed index of each expected grant into a
// queue; a monitor pops and compares whenever the DUT asserts a grant.
// Cycle-specific observations (lock stability, idle, credit exhaustion,
// reset values) are compared directly by the driver.

module tb_obi_credit_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned MO = 2;
  localparam int unsigned WW = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [N*WW-1:0] weight;
  logic          mgr_req;
  logic          mgr_gnt;
  logic [1:0]    sel;
  logic          rsp_valid;
  logic [1:0]    rsp_idx;
  logic          idle;

  int tests = 0;
  int fails = 0;
  int unsigned exp_q[$];

  obi_credit_arb #(
    .NumSbrPorts   (N),
    .MaxOutstanding(MO),
    .WeightWidth   (WW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .gnt_o      (gnt),
    .weight_i   (weight),
    .mgr_req_o  (mgr_req),
    .mgr_gnt_i  (mgr_gnt),
    .sel_idx_o  (sel),
    .rsp_valid_i(rsp_valid),
    .rsp_idx_i  (rsp_idx),
    .idle_o     (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic drive(input logic [N-1:0] r, input logic g, input logic rv, input logic [1:0] ri);
    @(posedge clk);
    #1;
    req       = r;
    mgr_gnt   = g;
    rsp_valid = rv;
    rsp_idx   = ri;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    req = '0; mgr_gnt = 1'b0; rsp_valid = 1'b0; rsp_idx = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_mgr_req", mgr_req, 0);
    chk("rst_sel", sel, 0);
    chk("rst_idle", idle, 1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Grant monitor
  always @(negedge clk) begin
    int unsigned e;
    if (rst_n && (gnt !== '0)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_grant: got gnt=%b expected no grant", gnt);
      end else begin
        e = exp_q.pop_front();
        chk("grant_vec", gnt, 32'd1 << e);
        chk("grant_sel", sel, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned seq1 [8];
    seq1 = '{0, 0, 1, 2, 3, 0, 0, 1};
    rst_n = 1'b0;
    req = '0; mgr_gnt = 1'b0; rsp_valid = 1'b0; rsp_idx = '0;
    weight = 16'h1112;

    // ---- weighted round-robin: weights 3:1 2:1 1:1 0:2 ----
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(4'hF, 1'b1, c > 0, (c > 0) ? 2'(seq1[c-1]) : 2'd0);
      exp_q.push_back(seq1[c]);
      settle();
    end
    drive(4'h0, 1'b0, 1'b1, 2'd1);
    settle();
    chk("s1_not_idle_during_last_rsp", idle, 0);
    drive(4'h0, 1'b0, 1'b0, 2'd0);
    settle();
    chk("s1_idle", idle, 1);
    chk("s1_drained", exp_q.size(), 0);

    // ---- credit limit on a single requester ----
    weight = 16'h1111;
    do_reset();
    drive(4'b0100, 1'b1, 1'b0, 2'd0); exp_q.push_back(2); settle();
    drive(4'b0100, 1'b1, 1'b0, 2'd0); exp_q.push_back(2); settle();
    drive(4'b0100, 1'b1, 1'b0, 2'd0); settle();
    chk("s2_full_gnt", gnt, 0);
    chk("s2_full_mgr_req", mgr_req, 0);
    chk("s2_full_sel_ptr", sel, 3);
    drive(4'b0100, 1'b1, 1'b1, 2'd2); settle();
    chk("s2_retire_cycle_gnt", gnt, 0);
    drive(4'b0100, 1'b1, 1'b0, 2'd0); exp_q.push_back(2); settle();
    chk("s2_regrant_mgr_req", mgr_req, 1);
    drive(4'h0, 1'b0, 1'b1, 2'd2); settle();
    drive(4'h0, 1'b0, 1'b1, 2'd2); settle();
    drive(4'h0, 1'b0, 1'b0, 2'd0); settle();
    chk("s2_idle", idle, 1);
    chk("s2_drained", exp_q.size(), 0);

    // ---- lock holds selection while ptr favours port 3 ----
    do_reset();
    drive(4'b0100, 1'b1, 1'b0, 2'd0); exp_q.push_back(2); settle();
    drive(4'b0000, 1'b0, 1'b1, 2'd2); settle();
    drive(4'b0010, 1'b0, 1'b0, 2'd0); settle();
    chk("s3_lock_sel_c0", sel, 1);
    chk("s3_lock_mgr_req", mgr_req, 1);
    chk("s3_lock_gnt", gnt, 0);
    drive(4'b1010, 1'b0, 1'b0, 2'd0); settle();
    chk("s3_lock_sel_c1", sel, 1);
    drive(4'b1010, 1'b0, 1'b0, 2'd0); settle();
    chk("s3_lock_sel_c2", sel, 1);
    drive(4'b1010, 1'b1, 1'b0, 2'd0); exp_q.push_back(1); settle();
    chk("s3_gnt_sel", sel, 1);
    drive(4'b1000, 1'b1, 1'b0, 2'd0); exp_q.push_back(3); settle();
    drive(4'h0, 1'b0, 1'b1, 2'd1); settle();
    drive(4'h0, 1'b0, 1'b1, 2'd3); settle();
    drive(4'h0, 1'b0, 1'b0, 2'd0); settle();
    chk("s3_idle", idle, 1);
    chk("s3_drained", exp_q.size(), 0);

    // ---- simultaneous grant and retire on the same port ----
    do_reset();
    drive(4'b0001, 1'b1, 1'b0, 2'd0); exp_q.push_back(0); settle();
    drive(4'b0001, 1'b1, 1'b1, 2'd0); exp_q.push_back(0); settle();
    drive(4'b0001, 1'b1, 1'b0, 2'd0); exp_q.push_back(0); settle();
    chk("s4_idle_after_same_cycle", idle, 0);
    drive(4'b0001, 1'b1, 1'b0, 2'd0); settle();
    chk("s4_credit_full_mgr_req", mgr_req, 0);
    chk("s4_credit_full_gnt", gnt, 0);
    drive(4'h0, 1'b0, 1'b1, 2'd0); settle();
    drive(4'h0, 1'b0, 1'b1, 2'd0); settle();
    drive(4'h0, 1'b0, 1'b0, 2'd0); settle();
    chk("s4_idle", idle, 1);
    chk("s4_drained", exp_q.size(), 0);

    // ---- asynchronous reset with transactions outstanding ----
    do_reset();
    drive(4'b0011, 1'b1, 1'b0, 2'd0); exp_q.push_back(0); settle();
    drive(4'b0011, 1'b1, 1'b0, 2'd0); exp_q.push_back(1); settle();
    drive(4'b0000, 1'b1, 1'b0, 2'd0); settle();
    chk("s5_pre_sel", sel, 2);
    chk("s5_pre_idle", idle, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_async_gnt", gnt, 0);
    chk("s5_async_idle", idle, 1);
    chk("s5_async_sel", sel, 0);
    chk("s5_async_mgr_req", mgr_req, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    drive(4'h0, 1'b0, 1'b1, 2'd0); settle();
    chk("s5_late_rsp0_idle", idle, 1);
    drive(4'h0, 1'b0, 1'b1, 2'd1); settle();
    chk("s5_late_rsp1_idle", idle, 1);
    drive(4'h0, 1'b0, 1'b0, 2'd0); settle();
    chk("s5_late_idle", idle, 1);
    drive(4'b0001, 1'b1, 1'b0, 2'd0); exp_q.push_back(0); settle();
    drive(4'b0001, 1'b1, 1'b0, 2'd0); exp_q.push_back(0); settle();
    drive(4'b0001, 1'b1, 1'b0, 2'd0); settle();
    chk("s5_credit_full_mgr_req", mgr_req, 0);
    drive(4'h0, 1'b0, 1'b1, 2'd0); settle();
    drive(4'h0, 1'b0, 1'b1, 2'd0); settle();
    drive(4'h0, 1'b0, 1'b0, 2'd0); settle();
    chk("s5_idle", idle, 1);
    chk("s5_drained", exp_q.size(), 0);

    // ---- zero weight behaves as weight 1 ----
    weight = 16'h1101;
    do_reset();
    drive(4'b0110, 1'b1, 1'b0, 2'd0); exp_q.push_back(1); settle();
    drive(4'b0110, 1'b1, 1'b0, 2'd0); exp_q.push_back(2); settle();
    drive(4'b0110, 1'b1, 1'b0, 2'd0); exp_q.push_back(1); settle();
    drive(4'b0110, 1'b1, 1'b0, 2'd0); exp_q.push_back(2); settle();
    drive(4'b0110, 1'b1, 1'b0, 2'd0); settle();
    chk("s6_credit_full_mgr_req", mgr_req, 0);
    drive(4'h0, 1'b0, 1'b1, 2'd1); settle();
    drive(4'h0, 1'b0, 1'b1, 2'd2); settle();
    drive(4'h0, 1'b0, 1'b1, 2'd1); settle();
    drive(4'h0, 1'b0, 1'b1, 2'd2); settle();
    drive(4'h0, 1'b0, 1'b0, 2'd0); settle();
    chk("s6_idle", idle, 1);
    chk("s6_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
